hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Sequencing controller for the multi-cycle multiply and divide units and owner of the architectural HI/LO registers. It accepts one HI/LO operation at a time from the main control unit and stalls it with Busy. It launches the selected unit and waits for its completion handshake. It applies sign correction to divider results, then commits HI/LO. Divide-by-zero and unit hangs are reported as one-cycle exception pulses, and HI/LO is left unchanged in both cases.

## Interface
- TIMEOUT, default 48: maximum cycles spent in WAIT before the operation is aborted.
- Clock  in  1  rising-edge clock for all state in this block.
- Reset  in  1  reset, synchronous, active-low.
- Start  in  1  operation request; sampled only when Busy=0.
- Op  in  2  operation select: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- A  in  32  dividend / multiplicand / move source.
- B  in  32  divisor / multiplier.
- DivStart  out  1  one-cycle launch pulse to the divider.
- DivA  out  32  registered divider operand A, stable from ISSUE until return to IDLE.
- DivB  out  32  registered divider operand B, same stability.
- DivDone  in  1  divider level: 1 = idle / result valid.
- DivHigh  in  32  divider quotient magnitude.
- DivLow  in  32  divider remainder magnitude.
- DivZero  in  1  divider divide-by-zero flag.
- MulStart  out  1  one-cycle launch pulse to the multiplier.
- MulA  out  32  registered multiplier operand A.
- MulB  out  32  registered multiplier operand B.
- MulDone  in  1  multiplier level: 1 = idle / result valid.
- MulHigh  in  32  product bits 63:32.
- MulLow  in  32  product bits 31:0.
- Busy  out  1  stall to the main control.
- Done  out  1  one-cycle pulse on successful commit.
- Hi  out  32  architectural HI register.
- Lo  out  32  architectural LO register.
- DivZeroExc  out  1  one-cycle exception pulse.
- TimeoutExc  out  1  one-cycle exception pulse.

## Operation
- States are IDLE, ISSUE, GUARD, WAIT, WRITE. All outputs are registered.
- IDLE, Start=1, Op=MTHI or MTLO:
  - Hi (or Lo) <= A on the same edge.
  - Done pulses on the next cycle. Busy stays 0 throughout.
- IDLE, Start=1, Op=MULT or DIV:
  - Latch A, B and Op.
  - Latch sA=A[31] and sB=B[31] for DIV.
  - Go to ISSUE.
- ISSUE: Busy=1, DivStart or MulStart=1 for exactly this cycle. Go to GUARD.
- GUARD: one cycle in which DivDone/MulDone is ignored, because the unit may still show the previous result. Go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - Selected Done=1 → WRITE.
  - Counter reaches TIMEOUT → IDLE, TimeoutExc pulse, HI/LO unchanged.
- WRITE, MULT: Hi <= MulHigh, Lo <= MulLow. The multiplier is signed and its result is used as-is.
- WRITE, DIV:
  - Lo <= (sA^sB) ? -DivHigh : DivHigh.
  - Hi <= sA ? -DivLow : DivLow.
  - Negation is 32-bit two's complement with wrap.
  - The quotient of 0x80000000 / 0xFFFFFFFF is 0x80000000.
- WRITE with DivZero=1: HI/LO unchanged, DivZeroExc pulses instead of Done.
- WRITE always returns to IDLE. Done or the exception output pulses in the WRITE cycle.
- Start while Busy=1 is ignored and not queued.
- Reset=0 at any state, including mid-WAIT:
  - Next edge: IDLE, Hi=Lo=0, DivA/DivB/MulA/MulB=0.
  - All pulses and Busy = 0, counter = 0.
  - A unit left running is harmless because GUARD masks its stale Done.

## Timing
- MT*: Start at edge n, register written at edge n; Done high in cycle n+1.
- MULT/DIV:
  - Start sampled at edge n; ISSUE in cycle n+1, GUARD n+2, WAIT from n+3.
  - WRITE is the cycle after DivDone/MulDone is first seen high in WAIT.
  - Busy=1 from cycle n+1 through WRITE inclusive.
  - Back-to-back: a new Start is accepted in the cycle after WRITE.
- Minimum MULT/DIV latency is 5 cycles from Start to Done.
- The divider samples on the falling edge. DivStart and operands are held for a full cycle, so the divider sees them on that falling edge.

## Test plan
- Reset=0 for 2 cycles with all inputs at X-free random values → Hi=Lo=0, Busy=0, no pulses.
- DIV A=-7 (0xFFFFFFF9), B=2; divider model returns quotient 3, remainder 1 after 33 cycles → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF, Done pulse, Busy low the next cycle.
- DIV A=100, B=0; model returns DivZero=1 and DivDone=1 → DivZeroExc pulse, Hi/Lo keep the prior values (preload 0x1234 via MTHI first).
- MULT A=0xFFFFFFFF, B=2; model returns product 0xFFFFFFFF_FFFFFFFE → Hi=0xFFFFFFFF, Lo=0xFFFFFFFE. Start pulsed again during Busy is ignored, giving exactly one MulStart.
- Divider model never raises DivDone (held 0 after GUARD) → TimeoutExc exactly TIMEOUT cycles into WAIT, Busy drops, Hi/Lo unchanged.
- Reset=0 asserted mid-WAIT of a DIV, then a new DIV 9/3 is issued while the model still holds stale DivDone=1 → stale Done is masked by GUARD, and the final Lo=3, Hi=0.

Source files
------------

// File: rtl/hilo_ctrl.sv
// HI/LO sequencing controller: launches the multiplier or divider, waits for its
// completion handshake, sign-corrects divider results and commits HI/LO.
module hilo_ctrl #(
    parameter int unsigned TIMEOUT = 48
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        DivStart,
    output logic [31:0] DivA,
    output logic [31:0] DivB,
    input  logic        DivDone,
    input  logic [31:0] DivHigh,
    input  logic [31:0] DivLow,
    input  logic        DivZero,
    output logic        MulStart,
    output logic [31:0] MulA,
    output logic [31:0] MulB,
    input  logic        MulDone,
    input  logic [31:0] MulHigh,
    input  logic [31:0] MulLow,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        DivZeroExc,
    output logic        TimeoutExc
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, WRITE} state_t;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_DIV = 2'b01, OP_MTHI = 2'b10, OP_MTLO = 2'b11} op_t;

    state_t         state_q, state_d;
    logic           is_div_q, is_div_d;
    logic [31:0]    div_a_q, div_a_d, div_b_q, div_b_d;
    logic [31:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           div_start_q, div_start_d;
    logic           mul_start_q, mul_start_d;
    logic           dz_exc_q, dz_exc_d;
    logic           to_exc_q, to_exc_d;

    op_t            op_in;
    logic           unit_done;
    logic           s_a, s_b;
    logic [31:0]    quot_fix, rem_fix;

    assign op_in     = op_t'(Op);
    assign unit_done = is_div_q ? DivDone : MulDone;
    assign s_a       = div_a_q[31];
    assign s_b       = div_b_q[31];
    assign quot_fix  = (s_a ^ s_b) ? (~DivHigh + 32'd1) : DivHigh;
    assign rem_fix   = s_a ? (~DivLow + 32'd1) : DivLow;

    always_comb begin
        state_d     = state_q;
        is_div_d    = is_div_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        div_start_d = 1'b0;
        mul_start_d = 1'b0;
        dz_exc_d    = 1'b0;
        to_exc_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (op_in)
                        OP_MTHI: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                        OP_MULT: begin
                            mul_a_d     = A;
                            mul_b_d     = B;
                            is_div_d    = 1'b0;
                            mul_start_d = 1'b1;
                            state_d     = ISSUE;
                        end
                        default: begin
                            div_a_d     = A;
                            div_b_d     = B;
                            is_div_d    = 1'b1;
                            div_start_d = 1'b1;
                            state_d     = ISSUE;
                        end
                    endcase
                end
            end
            ISSUE: state_d = GUARD;
            GUARD: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Results are committed on entry to WRITE so HI/LO are valid while Done is high
                if (unit_done) begin
                    state_d = WRITE;
                    if (is_div_q && DivZero) begin
                        dz_exc_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        hi_d   = is_div_q ? rem_fix  : MulHigh;
                        lo_d   = is_div_q ? quot_fix : MulLow;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    to_exc_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            is_div_q    <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_start_q <= 1'b0;
            mul_start_q <= 1'b0;
            dz_exc_q    <= 1'b0;
            to_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_div_q    <= is_div_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_start_q <= div_start_d;
            mul_start_q <= mul_start_d;
            dz_exc_q    <= dz_exc_d;
            to_exc_q    <= to_exc_d;
        end
    end

    assign DivStart   = div_start_q;
    assign DivA       = div_a_q;
    assign DivB       = div_b_q;
    assign MulStart   = mul_start_q;
    assign MulA       = mul_a_q;
    assign MulB       = mul_b_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Hi         = hi_q;
    assign Lo         = lo_q;
    assign DivZeroExc = dz_exc_q;
    assign TimeoutExc = to_exc_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with simple behavioural multiplier/divider models
// whose Done level stays high with stale results for two cycles after a launch.
module tb_hilo_ctrl;

    localparam int unsigned TIMEOUT = 48;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A, B;
    logic        DivStart, MulStart;
    logic [31:0] DivA, DivB, MulA, MulB;
    logic        DivDone, DivZero, MulDone;
    logic [31:0] DivHigh, DivLow, MulHigh, MulLow;
    logic        Busy, Done, DivZeroExc, TimeoutExc;
    logic [31:0] Hi, Lo;

    hilo_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .DivStart(DivStart), .DivA(DivA), .DivB(DivB), .DivDone(DivDone),
        .DivHigh(DivHigh), .DivLow(DivLow), .DivZero(DivZero),
        .MulStart(MulStart), .MulA(MulA), .MulB(MulB), .MulDone(MulDone),
        .MulHigh(MulHigh), .MulLow(MulLow),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo),
        .DivZeroExc(DivZeroExc), .TimeoutExc(TimeoutExc)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    int start_cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int num_done, num_dz, num_to, done_at, dz_at, to_at, busy_low_at, div_starts, mul_starts;
    int div_cnt = 0, div_lat = 1, mul_cnt = 0, mul_lat = 1;
    logic [31:0] div_q, div_r, mul_hi, mul_lo;
    logic        div_z;

    logic [31:0] t_a   [3] = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000};
    logic [31:0] t_b   [3] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] t_q   [3] = '{32'd3,         32'd3,         32'h8000_0000};
    logic [31:0] t_r   [3] = '{32'd1,         32'd1,         32'd0};
    int          t_lat [3] = '{33, 5, 2};
    logic [31:0] t_lo  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] t_hi  [3] = '{32'hFFFF_FFFF, 32'd1,         32'd0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == div_lat) DivDone = 1'b0;
            if (div_cnt == 0) begin
                DivDone = 1'b1; DivHigh = div_q; DivLow = div_r; DivZero = div_z;
            end
        end
        if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == mul_lat) MulDone = 1'b0;
            if (mul_cnt == 0) begin
                MulDone = 1'b1; MulHigh = mul_hi; MulLow = mul_lo;
            end
        end
        if (DivStart) begin div_starts++; div_cnt = div_lat + 2; end
        if (MulStart) begin mul_starts++; mul_cnt = mul_lat + 2; end
        if (Done) begin num_done++; if (done_at < 0) done_at = cyc; end
        if (DivZeroExc) begin num_dz++; if (dz_at < 0) dz_at = cyc; end
        if (TimeoutExc) begin num_to++; if (to_at < 0) to_at = cyc; end
        if (!Busy && busy_low_at < 0) busy_low_at = cyc;
    endtask

    task automatic model_idle();
        div_cnt = 0; mul_cnt = 0;
        DivDone = 1'b1; MulDone = 1'b1; DivZero = 1'b0;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; A = a; B = b; Start = 1'b1;
        start_cyc = cyc;
        num_done = 0; num_dz = 0; num_to = 0;
        done_at = -1; dz_at = -1; to_at = -1; busy_low_at = -1;
        div_starts = 0; mul_starts = 0;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy_low_at < 0 && n < limit) begin
            tick();
            n++;
        end
        check_eq("reach_idle", (busy_low_at >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs
        Reset = 1'b0;
        Start = 1'($urandom); Op = 2'($urandom); A = $urandom; B = $urandom;
        DivDone = 1'($urandom); DivZero = 1'($urandom); DivHigh = $urandom; DivLow = $urandom;
        MulDone = 1'($urandom); MulHigh = $urandom; MulLow = $urandom;
        div_q = '0; div_r = '0; div_z = 1'b0; mul_hi = '0; mul_lo = '0;
        busy_low_at = -1; done_at = -1; dz_at = -1; to_at = -1;
        tick();
        tick();
        check_eq("rst_hi",   Hi, 32'd0);
        check_eq("rst_lo",   Lo, 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_puls", 32'({Done, DivStart, MulStart, DivZeroExc, TimeoutExc}), 32'd0);
        check_eq("rst_diva", DivA, 32'd0);
        check_eq("rst_mulb", MulB, 32'd0);
        Start = 1'b0;
        model_idle();
        Reset = 1'b1;
        tick();

        // MTHI / MTLO
        launch(2'b10, 32'h0000_1234, 32'd0);
        check_eq("mthi_hi",   Hi, 32'h0000_1234);
        check_eq("mthi_done", 32'(Done), 32'd1);
        check_eq("mthi_busy", 32'(Busy), 32'd0);
        launch(2'b11, 32'h0000_5678, 32'd0);
        check_eq("mtlo_lo",   Lo, 32'h0000_5678);
        check_eq("mtlo_done", 32'(Done), 32'd1);
        tick();
        check_eq("mt_done_clr", 32'(Done), 32'd0);

        // Divide by zero leaves HI/LO alone
        model_idle();
        div_lat = 1; div_q = '0; div_r = '0; div_z = 1'b1;
        launch(2'b01, 32'd100, 32'd0);
        wait_idle(50);
        check_eq("dz_at",   dz_at, start_cyc + 5);
        check_eq("dz_num",  num_dz, 1);
        check_eq("dz_done", num_done, 0);
        check_eq("dz_hi",   Hi, 32'h0000_1234);
        check_eq("dz_lo",   Lo, 32'h0000_5678);

        // Signed divide vectors
        for (int i = 0; i < 3; i++) begin
            model_idle();
            div_lat = t_lat[i]; div_q = t_q[i]; div_r = t_r[i]; div_z = 1'b0;
            launch(2'b01, t_a[i], t_b[i]);
            check_eq("div_start", 32'(DivStart), 32'd1);
            check_eq("div_busy",  32'(Busy), 32'd1);
            check_eq("div_a",     DivA, t_a[i]);
            check_eq("div_b",     DivB, t_b[i]);
            wait_idle(100);
            check_eq("div_lo",      Lo, t_lo[i]);
            check_eq("div_hi",      Hi, t_hi[i]);
            check_eq("div_done_at", done_at, start_cyc + t_lat[i] + 4);
            check_eq("div_idle_at", busy_low_at, start_cyc + t_lat[i] + 5);
            check_eq("div_ndone",   num_done, 1);
            check_eq("div_nstart",  div_starts, 1);
        end

        // Multiply, with a second Start while busy
        model_idle();
        mul_lat = 3; mul_hi = 32'hFFFF_FFFF; mul_lo = 32'hFFFF_FFFE;
        launch(2'b00, 32'hFFFF_FFFF, 32'd2);
        check_eq("mul_start", 32'(MulStart), 32'd1);
        check_eq("mul_a",     MulA, 32'hFFFF_FFFF);
        check_eq("mul_b",     MulB, 32'd2);
        Start = 1'b1; Op = 2'b00;
        tick();
        Start = 1'b0;
        wait_idle(100);
        check_eq("mul_hi",      Hi, 32'hFFFF_FFFF);
        check_eq("mul_lo",      Lo, 32'hFFFF_FFFE);
        check_eq("mul_done_at", done_at, start_cyc + 7);
        check_eq("mul_nstart",  mul_starts, 1);

        // Divider never completes
        model_idle();
        div_lat = 1000;
        launch(2'b01, 32'd5, 32'd1);
        wait_idle(100);
        check_eq("to_at",    to_at, start_cyc + 3 + TIMEOUT);
        check_eq("to_num",   num_to, 1);
        check_eq("to_done",  num_done, 0);
        check_eq("to_idle",  busy_low_at, to_at);
        check_eq("to_hi",    Hi, 32'hFFFF_FFFF);
        check_eq("to_lo",    Lo, 32'hFFFF_FFFE);

        // Reset mid-WAIT, then a DIV against stale divider Done
        model_idle();
        div_lat = 1000;
        launch(2'b01, 32'd20, 32'd4);
        repeat (4) tick();
        check_eq("mid_busy", 32'(Busy), 32'd1);
        Reset = 1'b0;
        tick();
        check_eq("mrst_busy", 32'(Busy), 32'd0);
        check_eq("mrst_hi",   Hi, 32'd0);
        check_eq("mrst_lo",   Lo, 32'd0);
        check_eq("mrst_diva", DivA, 32'd0);
        check_eq("mrst_divb", DivB, 32'd0);
        Reset = 1'b1;
        div_cnt = 0; DivDone = 1'b1; DivZero = 1'b0;
        DivHigh = 32'hDEAD_0001; DivLow = 32'hDEAD_0002;
        div_lat = 4; div_q = 32'd3; div_r = 32'd0; div_z = 1'b0;
        launch(2'b01, 32'd9, 32'd3);
        wait_idle(100);
        check_eq("stale_lo",      Lo, 32'd3);
        check_eq("stale_hi",      Hi, 32'd0);
        check_eq("stale_done_at", done_at, start_cyc + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
